// File: rtl/bin_xfer_pkg.sv
// Shared types and the lane-placement helper for the bin transfer engine.
package bin_xfer_pkg;

    typedef enum logic [1:0] {IDLE, XC, XV, DONE} xfer_state_e;
    typedef enum logic {LOAD, UPDATE} xfer_mode_e;

    // Widest var-state bus the helper can build (WIDTH_VAR_STATES * NUM_VARS_A_BIN).
    localparam int VS_BUS_MAX = 2048;

    function automatic logic [VS_BUS_MAX-1:0] place_lane(
        input logic [VS_BUS_MAX-1:0] val,
        input int                    lane,
        input int                    width
    );
        logic [VS_BUS_MAX-1:0] mask;
        mask = (VS_BUS_MAX'(1) << width) - VS_BUS_MAX'(1);
        return (val & mask) << (lane * width);
    endfunction

endpackage

// File: rtl/bin_xfer_engine_if.sv
// Control handshake between bin_manager and the bin transfer engine.
interface bin_xfer_engine_if #(
    parameter int NUM_CLAUSES_A_BIN = 8,
    parameter int WIDTH_BIN_ID      = 10
);
    localparam int NCW = $clog2(NUM_CLAUSES_A_BIN) + 1;

    logic                    start_load_i;
    logic                    start_update_i;
    logic [WIDTH_BIN_ID-1:0] bin_id_i;
    logic [NCW-1:0]          nc_i;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;

    modport master (
        output start_load_i, start_update_i, bin_id_i, nc_i,
        input  busy_o, done_o, err_o
    );

    modport slave (
        input  start_load_i, start_update_i, bin_id_i, nc_i,
        output busy_o, done_o, err_o
    );
endinterface

// File: rtl/bin_xfer_engine_onehot_dec.sv
// Index to one-hot decoder with enable; all zeros when disabled.
module onehot_dec #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [N-1:0]     oh_o
);
    assign oh_o = en_i ? (N'(1) << idx_i) : '0;
endmodule

// File: rtl/bin_xfer_engine.sv
// Moves one bin between the clause / var-state RAMs and the sat engine core,
// with a fixed NC+NV+2 cycle latency from start to done.
module bin_xfer_engine
    import bin_xfer_pkg::*;
#(
    parameter int NUM_CLAUSES_A_BIN      = 8,
    parameter int NUM_VARS_A_BIN         = 8,
    parameter int NUM_BINS               = 64,
    parameter int WIDTH_BIN_ID           = 10,
    parameter int WIDTH_VAR_STATES       = 19,
    parameter int ADDR_WIDTH_CLAUSES     = 9,
    parameter int ADDR_WIDTH_VARS_STATES = 9
) (
    input  logic                                       clk,
    input  logic                                       rst,
    bin_xfer_engine_if.slave                           ctl,
    output logic [ADDR_WIDTH_CLAUSES-1:0]              ram_addr_c_o,
    input  logic [2*NUM_VARS_A_BIN-1:0]                ram_dout_c_i,
    output logic                                       ram_we_c_o,
    output logic [2*NUM_VARS_A_BIN-1:0]                ram_din_c_o,
    output logic [ADDR_WIDTH_VARS_STATES-1:0]          ram_addr_vs_o,
    input  logic [WIDTH_VAR_STATES-1:0]                ram_dout_vs_i,
    output logic                                       ram_we_vs_o,
    output logic [WIDTH_VAR_STATES-1:0]                ram_din_vs_o,
    output logic [NUM_CLAUSES_A_BIN-1:0]               wr_carray_o,
    output logic [NUM_CLAUSES_A_BIN-1:0]               rd_carray_o,
    output logic [2*NUM_VARS_A_BIN-1:0]                clause_o,
    input  logic [2*NUM_VARS_A_BIN-1:0]                clause_i,
    output logic [NUM_VARS_A_BIN-1:0]                  wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] vars_states_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] vars_states_i
);
    localparam int NC     = NUM_CLAUSES_A_BIN;
    localparam int NV     = NUM_VARS_A_BIN;
    localparam int NCW    = $clog2(NC) + 1;
    localparam int MAXN   = (NC > NV) ? NC : NV;
    localparam int CNT_W  = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam int VW     = WIDTH_VAR_STATES;
    localparam int VSW    = VW * NV;
    localparam int AC_W   = ADDR_WIDTH_CLAUSES;
    localparam int AV_W   = ADDR_WIDTH_VARS_STATES;
    localparam int PROD_W = WIDTH_BIN_ID + CNT_W + 1;

    function automatic logic [NCW-1:0] clamp_nc(input logic [NCW-1:0] n);
        return (32'(n) > 32'(NC)) ? NCW'(NC) : n;
    endfunction

    xfer_state_e      state_q;
    xfer_mode_e       mode_q;
    logic [NCW-1:0]   nc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q, err_q;
    logic             vld_p1_q, var_p1_q, wr_p1_q;
    logic [CNT_W-1:0] idx_p1_q;
    logic [AC_W-1:0]  cbase_q, cbase_d;
    logic [AV_W-1:0]  vbase_q, vbase_d;
    logic [VSW-1:0]   snap_q;

    logic any_start, both_start, bin_ok, accept, reject;
    logic in_xc, in_xv, slot_live;
    logic [PROD_W-1:0] cprod, vprod;

    assign any_start  = ctl.start_load_i | ctl.start_update_i;
    assign both_start = ctl.start_load_i & ctl.start_update_i;
    assign bin_ok     = 32'(ctl.bin_id_i) < 32'(NUM_BINS);
    assign accept     = (state_q == IDLE) && any_start && !both_start && bin_ok;
    assign reject     = any_start && !accept;

    // Bases are formed at full product width; only the low address bits are kept.
    assign cprod   = PROD_W'(ctl.bin_id_i) * PROD_W'(NC);
    assign vprod   = PROD_W'(ctl.bin_id_i) * PROD_W'(NV);
    assign cbase_d = AC_W'(cprod);
    assign vbase_d = AV_W'(vprod);

    assign in_xc     = (state_q == XC);
    assign in_xv     = (state_q == XV);
    assign slot_live = 32'(cnt_q) < 32'(nc_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= LOAD;
            nc_q     <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            vld_p1_q <= 1'b0;
            var_p1_q <= 1'b0;
            wr_p1_q  <= 1'b0;
            idx_p1_q <= '0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= reject;
            vld_p1_q <= in_xc | in_xv;
            var_p1_q <= in_xv;
            wr_p1_q  <= in_xv | slot_live;
            idx_p1_q <= cnt_q;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= XC;
                        mode_q  <= ctl.start_update_i ? UPDATE : LOAD;
                        nc_q    <= clamp_nc(ctl.nc_i);
                        cnt_q   <= '0;
                    end
                end
                XC: begin
                    if (32'(cnt_q) == 32'(NC - 1)) begin
                        state_q <= XV;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                XV: begin
                    if (32'(cnt_q) == 32'(NV - 1)) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data-only registers: every use is gated by the reset control state.
    always_ff @(posedge clk) begin
        if (accept) begin
            cbase_q <= cbase_d;
            vbase_q <= vbase_d;
        end
        if (in_xv && cnt_q == '0) begin
            snap_q <= vars_states_i;
        end
    end

    assign ctl.busy_o = (state_q != IDLE);
    assign ctl.done_o = done_q;
    assign ctl.err_o  = err_q;

    // ---- p0: address issue from the shared counter ----
    logic ld_rd_c_p0, ld_rd_v_p0, up_rd_c_p0;
    assign ld_rd_c_p0 = (mode_q == LOAD) && in_xc && slot_live;
    assign ld_rd_v_p0 = (mode_q == LOAD) && in_xv;
    assign up_rd_c_p0 = (mode_q == UPDATE) && in_xc && slot_live;

    // ---- p1: data stage, one cycle behind the address ----
    logic ld_c_p1, ld_v_p1;
    assign ld_c_p1     = vld_p1_q && !var_p1_q && (mode_q == LOAD);
    assign ld_v_p1     = vld_p1_q && var_p1_q && (mode_q == LOAD);
    assign ram_we_c_o  = vld_p1_q && !var_p1_q && wr_p1_q && (mode_q == UPDATE);
    assign ram_we_vs_o = vld_p1_q && var_p1_q && (mode_q == UPDATE);

    always_comb begin
        ram_addr_c_o = '0;
        if (ld_rd_c_p0) begin
            ram_addr_c_o = cbase_q + AC_W'(cnt_q);
        end else if (ram_we_c_o) begin
            ram_addr_c_o = cbase_q + AC_W'(idx_p1_q);
        end
    end

    always_comb begin
        ram_addr_vs_o = '0;
        if (ld_rd_v_p0) begin
            ram_addr_vs_o = vbase_q + AV_W'(cnt_q);
        end else if (ram_we_vs_o) begin
            ram_addr_vs_o = vbase_q + AV_W'(idx_p1_q);
        end
    end

    // Slots at or above nc are still strobed, with zero data, to clear them.
    assign clause_o      = (ld_c_p1 && wr_p1_q) ? ram_dout_c_i : '0;
    assign vars_states_o = ld_v_p1
        ? VSW'(place_lane(VS_BUS_MAX'(ram_dout_vs_i), int'(idx_p1_q), VW)) : '0;
    assign ram_din_c_o   = ram_we_c_o ? clause_i : '0;
    assign ram_din_vs_o  = ram_we_vs_o ? snap_q[int'(idx_p1_q)*VW +: VW] : '0;

    onehot_dec #(.N(NC), .IDX_W(CNT_W)) u_wr_c (
        .idx_i(idx_p1_q), .en_i(ld_c_p1), .oh_o(wr_carray_o)
    );

    onehot_dec #(.N(NC), .IDX_W(CNT_W)) u_rd_c (
        .idx_i(cnt_q), .en_i(up_rd_c_p0), .oh_o(rd_carray_o)
    );

    onehot_dec #(.N(NV), .IDX_W(CNT_W)) u_wr_v (
        .idx_i(idx_p1_q), .en_i(ld_v_p1), .oh_o(wr_var_states_o)
    );

endmodule

// File: tb/tb_bin_xfer_engine.sv
// Directed bench for bin_xfer_engine with NC = NV = 8 and four bins.
module tb_bin_xfer_engine;
    logic clk;
    logic rst;

    logic [8:0]   ram_addr_c, ram_addr_vs;
    logic [15:0]  ram_dout_c, ram_din_c, clause_o, clause_i;
    logic [18:0]  ram_dout_vs, ram_din_vs;
    logic         ram_we_c, ram_we_vs;
    logic [7:0]   wr_carray, rd_carray, wr_var;
    logic [151:0] vs_out, vs_in;

    int checks;
    int failures;

    bin_xfer_engine_if #(.NUM_CLAUSES_A_BIN(8), .WIDTH_BIN_ID(10)) ctl ();

    bin_xfer_engine #(
        .NUM_CLAUSES_A_BIN(8), .NUM_VARS_A_BIN(8), .NUM_BINS(4), .WIDTH_BIN_ID(10),
        .WIDTH_VAR_STATES(19), .ADDR_WIDTH_CLAUSES(9), .ADDR_WIDTH_VARS_STATES(9)
    ) dut (
        .clk(clk), .rst(rst), .ctl(ctl),
        .ram_addr_c_o(ram_addr_c), .ram_dout_c_i(ram_dout_c), .ram_we_c_o(ram_we_c),
        .ram_din_c_o(ram_din_c), .ram_addr_vs_o(ram_addr_vs), .ram_dout_vs_i(ram_dout_vs),
        .ram_we_vs_o(ram_we_vs), .ram_din_vs_o(ram_din_vs), .wr_carray_o(wr_carray),
        .rd_carray_o(rd_carray), .clause_o(clause_o), .clause_i(clause_i),
        .wr_var_states_o(wr_var), .vars_states_o(vs_out), .vars_states_i(vs_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_c(input int a);
        return (a >= 16 && a < 24) ? 16'(a - 15) : (16'hC000 | 16'(a));
    endfunction

    function automatic logic [18:0] init_v(input int a);
        return 19'h40000 | 19'(a * 3);
    endfunction

    // RAMs with one-cycle read latency, reloaded while reset is held.
    logic [15:0] mem_c  [0:511];
    logic [18:0] mem_vs [0:511];
    always @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < 512; a++) begin
                mem_c[a]  <= init_c(a);
                mem_vs[a] <= init_v(a);
            end
        end else begin
            if (ram_we_c)  mem_c[ram_addr_c]   <= ram_din_c;
            if (ram_we_vs) mem_vs[ram_addr_vs] <= ram_din_vs;
        end
        ram_dout_c  <= mem_c[ram_addr_c];
        ram_dout_vs <= mem_vs[ram_addr_vs];
    end

    // Core returns A5A5^k the cycle after slot k is read.
    always @(posedge clk) begin
        clause_i <= 16'h0;
        for (int k = 0; k < 8; k++) if (rd_carray[k]) clause_i <= 16'hA5A5 ^ 16'(k);
    end

    logic [249:0] all_out;
    assign all_out = {ctl.busy_o, ctl.done_o, ctl.err_o, ram_addr_c, ram_we_c, ram_din_c,
                      ram_addr_vs, ram_we_vs, ram_din_vs, wr_carray, rd_carray, clause_o,
                      wr_var, vs_out};

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_held outputs got=%h exp=0", all_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_released outputs got=%h exp=0", all_out); end
    endtask

    task automatic test_load(input int bin, input int nc, input int poke_c, input string nm);
        int nce, cb, k, j, max_a;
        logic e_busy, e_done, e_err;
        logic [8:0] e_ac, e_av;
        logic [7:0] e_wrc, e_wrv;
        logic [15:0] e_cl;
        logic [151:0] e_vs;
        nce = (nc > 8) ? 8 : nc;
        cb = bin * 8;
        max_a = 0;
        @(posedge clk); #1;
        ctl.start_load_i = 1'b1; ctl.bin_id_i = 10'(bin); ctl.nc_i = 4'(nc);
        @(posedge clk); #1;
        ctl.start_load_i = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            ctl.start_load_i = (c == poke_c);
            if (c == poke_c) ctl.bin_id_i = 10'd0;
            @(negedge clk);
            k = c - 2; j = c - 10;
            e_busy = (c <= 17); e_done = (c == 18);
            e_err = (poke_c > 0) && (c == poke_c + 1);
            e_ac = (c <= 8 && c - 1 < nce) ? 9'(cb + c - 1) : 9'd0;
            e_wrc = (k >= 0 && k < 8) ? 8'(1 << k) : 8'd0;
            e_cl = (k >= 0 && k < nce) ? init_c(cb + k) : 16'd0;
            e_av = (c >= 9 && c <= 16) ? 9'(cb + c - 9) : 9'd0;
            e_wrv = (j >= 0 && j < 8) ? 8'(1 << j) : 8'd0;
            e_vs = '0;
            if (j >= 0 && j < 8) e_vs[j*19 +: 19] = init_v(cb + j);
            checks++; if (ctl.busy_o !== e_busy) begin failures++; $display("FAIL %s c=%0d busy got=%0b exp=%0b", nm, c, ctl.busy_o, e_busy); end
            checks++; if (ctl.done_o !== e_done) begin failures++; $display("FAIL %s c=%0d done got=%0b exp=%0b", nm, c, ctl.done_o, e_done); end
            checks++; if (ctl.err_o !== e_err) begin failures++; $display("FAIL %s c=%0d err got=%0b exp=%0b", nm, c, ctl.err_o, e_err); end
            checks++; if (ram_addr_c !== e_ac) begin failures++; $display("FAIL %s c=%0d addr_c got=%0d exp=%0d", nm, c, ram_addr_c, e_ac); end
            checks++; if (wr_carray !== e_wrc) begin failures++; $display("FAIL %s c=%0d wr_carray got=%b exp=%b", nm, c, wr_carray, e_wrc); end
            checks++; if (clause_o !== e_cl) begin failures++; $display("FAIL %s c=%0d clause_o got=%h exp=%h", nm, c, clause_o, e_cl); end
            checks++; if (ram_addr_vs !== e_av) begin failures++; $display("FAIL %s c=%0d addr_vs got=%0d exp=%0d", nm, c, ram_addr_vs, e_av); end
            checks++; if (wr_var !== e_wrv) begin failures++; $display("FAIL %s c=%0d wr_var got=%b exp=%b", nm, c, wr_var, e_wrv); end
            checks++; if (vs_out !== e_vs) begin failures++; $display("FAIL %s c=%0d vars_states got=%h exp=%h", nm, c, vs_out, e_vs); end
            checks++; if ({rd_carray, ram_we_c, ram_we_vs} !== 10'd0) begin failures++; $display("FAIL %s c=%0d update_strobes got=%b exp=0", nm, c, {rd_carray, ram_we_c, ram_we_vs}); end
            if (int'(ram_addr_c) > max_a) max_a = int'(ram_addr_c);
            @(posedge clk); #1;
        end
        checks++; if (max_a !== cb + nce - 1) begin failures++; $display("FAIL %s max_read_addr got=%0d exp=%0d", nm, max_a, cb + nce - 1); end
    endtask

    task automatic test_update();
        int k, j;
        logic e_busy, e_done, e_wc, e_wv;
        logic [8:0] e_ac, e_av;
        logic [7:0] e_rdc;
        logic [15:0] e_dc;
        logic [18:0] e_dv;
        @(posedge clk); #1;
        ctl.start_update_i = 1'b1; ctl.bin_id_i = 10'd3; ctl.nc_i = 4'd8;
        @(posedge clk); #1;
        ctl.start_update_i = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            k = c - 2; j = c - 10;
            e_busy = (c <= 17); e_done = (c == 18);
            e_rdc = (c <= 8) ? 8'(1 << (c - 1)) : 8'd0;
            e_wc = (k >= 0 && k < 8);
            e_ac = e_wc ? 9'(24 + k) : 9'd0;
            e_dc = e_wc ? (16'hA5A5 ^ 16'(k)) : 16'd0;
            e_wv = (j >= 0 && j < 8);
            e_av = e_wv ? 9'(24 + j) : 9'd0;
            e_dv = e_wv ? 19'(19'h50000 + 19'(j * 19'h1111)) : 19'd0;
            checks++; if (ctl.busy_o !== e_busy) begin failures++; $display("FAIL update c=%0d busy got=%0b exp=%0b", c, ctl.busy_o, e_busy); end
            checks++; if (ctl.done_o !== e_done) begin failures++; $display("FAIL update c=%0d done got=%0b exp=%0b", c, ctl.done_o, e_done); end
            checks++; if (rd_carray !== e_rdc) begin failures++; $display("FAIL update c=%0d rd_carray got=%b exp=%b", c, rd_carray, e_rdc); end
            checks++; if ({ram_we_c, ram_addr_c, ram_din_c} !== {e_wc, e_ac, e_dc}) begin failures++; $display("FAIL update c=%0d clause_write got=%b/%0d/%h exp=%b/%0d/%h", c, ram_we_c, ram_addr_c, ram_din_c, e_wc, e_ac, e_dc); end
            checks++; if ({ram_we_vs, ram_addr_vs, ram_din_vs} !== {e_wv, e_av, e_dv}) begin failures++; $display("FAIL update c=%0d var_write got=%b/%0d/%h exp=%b/%0d/%h", c, ram_we_vs, ram_addr_vs, ram_din_vs, e_wv, e_av, e_dv); end
            checks++; if ({wr_carray, wr_var, clause_o, vs_out} !== '0) begin failures++; $display("FAIL update c=%0d load_strobes got=%b/%b exp=0", c, wr_carray, wr_var); end
            @(posedge clk); #1;
        end
        for (int a = 0; a < 8; a++) begin
            checks++; if (mem_c[24 + a] !== (16'hA5A5 ^ 16'(a))) begin failures++; $display("FAIL update clause_ram[%0d] got=%h exp=%h", 24 + a, mem_c[24 + a], 16'hA5A5 ^ 16'(a)); end
            checks++; if (mem_vs[24 + a] !== 19'(19'h50000 + 19'(a * 19'h1111))) begin failures++; $display("FAIL update var_ram[%0d] got=%h exp=%h", 24 + a, mem_vs[24 + a], 19'(19'h50000 + 19'(a * 19'h1111))); end
        end
    endtask

    task automatic test_errors();
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            ctl.start_load_i = 1'b1; ctl.start_update_i = (t == 1);
            ctl.bin_id_i = (t == 0) ? 10'd4 : 10'd0; ctl.nc_i = 4'd8;
            @(posedge clk); #1;
            ctl.start_load_i = 1'b0; ctl.start_update_i = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                checks++; if (ctl.err_o !== (c == 1)) begin failures++; $display("FAIL reject%0d c=%0d err got=%0b exp=%0b", t, c, ctl.err_o, (c == 1)); end
                checks++; if ({ctl.busy_o, ctl.done_o, ram_we_c, ram_we_vs, wr_carray, rd_carray, wr_var, ram_addr_c, ram_addr_vs} !== '0) begin failures++; $display("FAIL reject%0d c=%0d activity got=%b/%b/%b exp=0", t, c, ctl.busy_o, wr_carray, rd_carray); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_abort();
        @(posedge clk); #1;
        ctl.start_load_i = 1'b1; ctl.bin_id_i = 10'd2; ctl.nc_i = 4'd8;
        @(posedge clk); #1;
        ctl.start_load_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (ctl.busy_o !== 1'b1) begin failures++; $display("FAIL abort pre_reset busy got=%0b exp=1", ctl.busy_o); end
        #1 rst = 1'b1;
        #1;
        checks++; if (all_out !== '0) begin failures++; $display("FAIL abort immediate outputs got=%h exp=0", all_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++; if ({ctl.busy_o, ctl.done_o} !== 2'b00) begin failures++; $display("FAIL abort c=%0d busy_done got=%b exp=00", c, {ctl.busy_o, ctl.done_o}); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        ctl.start_load_i = 1'b0;
        ctl.start_update_i = 1'b0;
        ctl.bin_id_i = '0;
        ctl.nc_i = '0;
        vs_in = '0;
        for (int j = 0; j < 8; j++) vs_in[j*19 +: 19] = 19'(19'h50000 + 19'(j * 19'h1111));
        test_reset();
        test_load(2, 8, 0, "load_full");
        test_load(1, 5, 0, "load_partial");
        test_load(0, 15, 5, "load_busy_reject");
        test_errors();
        test_update();
        test_reset_abort();
        test_load(2, 8, 0, "load_after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bin_xfer_engine.md
# bin_xfer_engine

- Parametrised DMA-style block that moves one bin between the bin RAMs (clause RAM, var-state RAM) and the sat engine core.
- Load mode streams clauses and var states from RAM into the core's clause array and var-state lanes. Update mode reads them back from the core and writes them to RAM.
- Sits between bin_manager's control FSM and the core. It generalises the fixed 8×8 load/update path with a per-bin valid-clause count, a bin-range check and deterministic fixed latency.

## Interface

Parameters:
- NUM_CLAUSES_A_BIN, 8, clause slots per bin (NC)
- NUM_VARS_A_BIN, 8, var-state lanes per bin (NV)
- NUM_BINS, 64, number of bins stored in RAM
- WIDTH_BIN_ID, 10, bin id width
- WIDTH_VAR_STATES, 19, bits per var state
- ADDR_WIDTH_CLAUSES, 9, clause RAM address width
- ADDR_WIDTH_VARS_STATES, 9, var-state RAM address width

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- start_load_i  in  1  one-cycle request: load bin_id_i into the core.
- start_update_i  in  1  one-cycle request: write the core's contents back to bin bin_id_i.
- bin_id_i  in  WIDTH_BIN_ID  target bin; sampled with start.
- nc_i  in  $clog2(NC)+1  valid clauses in the bin; sampled with start; clamped to NC.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse: request rejected.
- ram_addr_c_o  out  ADDR_WIDTH_CLAUSES  clause RAM address.
- ram_dout_c_i  in  2*NV  clause RAM read data; 1-cycle read latency.
- ram_we_c_o  out  1  clause RAM write enable.
- ram_din_c_o  out  2*NV  clause RAM write data.
- ram_addr_vs_o  out  ADDR_WIDTH_VARS_STATES  var-state RAM address.
- ram_dout_vs_i  in  WIDTH_VAR_STATES  var-state read data; 1-cycle read latency.
- ram_we_vs_o  out  1  var-state RAM write enable.
- ram_din_vs_o  out  WIDTH_VAR_STATES  var-state write data.
- wr_carray_o  out  NC  one-hot clause-slot write strobe to the core.
- rd_carray_o  out  NC  one-hot clause-slot read strobe to the core.
- clause_o  out  2*NV  clause to the core.
- clause_i  in  2*NV  clause from the core; valid the cycle after rd_carray_o.
- wr_var_states_o  out  NV  one-hot var-lane write strobe.
- vars_states_o  out  WIDTH_VAR_STATES*NV  lane j occupies slice j; other slices are 0.
- vars_states_i  in  WIDTH_VAR_STATES*NV  core var states; held stable during update.

## Operation

FSM states: IDLE, XC (clause phase), XV (var phase), DONE. A mode bit selects load or update.

Start handling:
- In IDLE, a start with bin_id_i < NUM_BINS latches bin_id_i, the clamped nc_i and the mode, then enters XC.
- The following start requests pulse err_o and cause no transfer:
  - start with bin_id_i ≥ NUM_BINS;
  - start_load_i and start_update_i asserted together;
  - any start while busy_o is high.

Address bases:
- Clause base = bin_id*NC; var base = bin_id*NV.
- Computed at full product width, then truncated to the address width.

Load mode:
- XC, slot k = 0..NC-1:
  - If k < nc, issue clause address base+k.
  - One cycle later, drive clause_o = ram_dout_c_i with wr_carray_o[k] = 1.
  - If k ≥ nc, issue no read and drive clause_o = 0 with wr_carray_o[k] = 1, which clears the slot.
- XV, lane j = 0..NV-1: issue var address vbase+j; one cycle later assert wr_var_states_o[j] with ram_dout_vs_i in slice j.

Update mode:
- XC, slot k:
  - If k < nc, assert rd_carray_o[k]. On the next cycle write clause_i to base+k (ram_we_c_o = 1).
  - If k ≥ nc, generate no strobe and no write; the slot cycle is still consumed.
- XV:
  - vars_states_i is snapshotted on entry to XV.
  - Lane j is written to vbase+j, one lane per cycle.

Phases are pipelined back to back: the first XV address issues in the cycle after the last XC address.

## Timing

- Start is sampled on edge E0. busy_o is high from cycle 1 through cycle NC+NV+1.
- Load:
  - Clause addresses on cycles 1..NC; wr_carray_o on cycles 2..NC+1.
  - Var addresses on cycles NC+1..NC+NV; wr_var_states_o on cycles NC+2..NC+NV+1.
- Update:
  - rd_carray_o on cycles 1..NC; clause writes on cycles 2..NC+1.
  - vars_states_i snapshot taken at cycle NC+1; var writes on cycles NC+2..NC+NV+1.
- done_o pulses on cycle NC+NV+2 and the FSM returns to IDLE. Latency is fixed regardless of nc.
- A new start is accepted in the cycle done_o is high.
- err_o is asserted on the cycle after the rejected start.
- Reset values: every output is 0 and the state is IDLE. Reset asserted mid-transfer aborts immediately; no partial done_o is produced and the RAM write enables drop asynchronously.
- At most one bit of each one-hot strobe bus is high in any cycle.

## Structure

- Package bin_xfer_pkg contains:
  - the state enum {IDLE, XC, XV, DONE} and the mode enum {LOAD, UPDATE};
  - a function that places a lane value into slice j of the vars bus.
- Sub-module onehot_dec (index → NC- or NV-wide one-hot with enable), instantiated for the clause and var strobes.
- One counter is shared by both phases; a 1-cycle delay register carries valid, index and write flag to the data stage.

## Test plan

Each scenario runs with NC = NV = 8 and NUM_BINS = 4.

1. Load, bin 2, nc = 8, clause RAM[16+k] = k+1:
   - wr_carray_o = 1<<k on cycle k+2 with clause_o = k+1;
   - var lanes 0..7 loaded from RAM[16..23];
   - done_o on cycle 18.
2. Load, bin 1, nc = 5:
   - slots 5..7 are strobed with clause_o = 0;
   - no clause RAM read is issued above address 12;
   - done_o on cycle 18.
3. Update, bin 3, nc = 8, core returns clause_i = 16'hA5A5^k:
   - RAM[24+k] is written with that value;
   - var RAM[24..31] = vars_states_i slices;
   - done_o on cycle 18.
4. Start with bin_id = 4 gives err_o = 1 with no RAM or core strobes. Simultaneous start_load_i and start_update_i also gives err_o.
5. start_load_i again at cycle 5 of a transfer gives err_o at cycle 6; the original transfer completes unchanged.
6. rst asserted at cycle 7 of a load:
   - all outputs go to 0 at once;
   - no done_o;
   - a fresh load after reset completes in 18 cycles.
